// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and hex-to-segment table for the seven-segment driver
package seg7_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  typedef enum logic [2:0] {SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G} seg_idx_e;
  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic logic [6:0] hex7(input logic [3:0] nibble);
    return HEX7_TABLE[nibble];
  endfunction
endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: nibble to active-low {g,f,e,d,c,b,a} segment pattern
import seg7_pkg::*;
module seg7_hex_decoder (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = hex7(nibble);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode display scanner with per-frame snapshot
import seg7_pkg::*;
module seg7_scan_driver #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [N_DIGITS-1:0]   digit_en_i,
  output logic [N_DIGITS-1:0]   an_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic                  frame_o
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_GUARD = PW'(GUARD);
  localparam logic [IW-1:0] I_LAST = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_ONE = N_DIGITS'(1);
  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [4*N_DIGITS-1:0] sh_digits;
  logic [N_DIGITS-1:0] sh_dp, sh_en;
  logic load_pend, slot_end, snap, blank;
  logic [6:0] seg_dec;
  assign slot_end = presc == P_LAST;
  assign snap = en && (load_pend || (slot_end && idx == I_LAST));
  assign blank = !en || presc < P_GUARD || !sh_en[idx];
  seg7_hex_decoder u_dec (
    .nibble(sh_digits[4*idx +: 4]),
    .seg   (seg_dec)
  );
  // slot prescaler and digit index; both freeze while disabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (en) begin
      presc <= slot_end ? '0 : presc + 1'b1;
      if (slot_end) idx <= idx == I_LAST ? '0 : idx + 1'b1;
    end
  end
  // shadow copy of all inputs, refreshed only at frame boundaries so no digit tears
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_en     <= '0;
      load_pend <= 1'b1;
    end else if (snap) begin
      sh_digits <= digits_i;
      sh_dp     <= dp_i;
      sh_en     <= digit_en_i;
      load_pend <= 1'b0;
    end
  end
  // registered pin drivers; guard window keeps all anodes off while segments change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_o    <= '1;
      seg_o   <= SEG_BLANK;
      dp_o    <= 1'b1;
      frame_o <= 1'b0;
    end else begin
      an_o    <= blank ? '1 : ~(AN_ONE << idx);
      seg_o   <= blank ? SEG_BLANK : seg_dec;
      dp_o    <= blank | ~sh_dp[idx];
      frame_o <= snap;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboarded directed test of the scan driver (N=4, DIV=4, GUARD=1)
module tb_seg7_scan_driver;
  localparam int N = 4;
  localparam int DIV = 4;
  localparam int G = 1;
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } out_t;
  localparam out_t BLANK = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, frame: 1'b0};
  logic clk = 1'b0;
  logic rst;
  logic en = 1'b1;
  logic [15:0] digits = 16'h3210;
  logic [3:0] dp_in = 4'h0;
  logic [3:0] den = 4'hF;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp, frame;
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  out_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int m_presc, m_idx;
  logic m_pend;
  logic [15:0] m_d;
  logic [3:0] m_dp, m_en;

  seg7_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(DIV), .GUARD(G)) dut (
    .clk(clk), .rst(rst), .en(en), .digits_i(digits), .dp_i(dp_in), .digit_en_i(den),
    .an_o(an), .seg_o(seg), .dp_o(dp), .frame_o(frame)
  );

  always #5 clk = ~clk;

  function automatic out_t dut_out();
    return '{an: an, seg: seg, dp: dp, frame: frame};
  endfunction

  function automatic void check(string tag, out_t got, out_t exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed an=%h seg=%h dp=%b frame=%b, expected an=%h seg=%h dp=%b frame=%b",
             tag, got.an, got.seg, got.dp, got.frame, exp.an, exp.seg, exp.dp, exp.frame);
    end
  endfunction

  task automatic expect_now(string tag, logic [3:0] a, logic [6:0] s, logic d, logic f);
    check(tag, dut_out(), '{an: a, seg: s, dp: d, frame: f});
  endtask

  task automatic model_reset();
    m_presc = 0;
    m_idx = 0;
    m_pend = 1'b1;
    m_d = '0;
    m_dp = '0;
    m_en = '0;
  endtask

  task automatic model_step();
    out_t e;
    logic snap;
    if (!rst) begin
      model_reset();
      q.push_back(BLANK);
      return;
    end
    e = BLANK;
    if (en && m_presc >= G && m_en[m_idx]) begin
      e.an = ~(4'b0001 << m_idx);
      e.seg = hex_tab[m_d[m_idx*4 +: 4]];
      e.dp = ~m_dp[m_idx];
    end
    snap = en && (m_pend || (m_presc == DIV - 1 && m_idx == N - 1));
    e.frame = snap;
    q.push_back(e);
    if (en) begin
      if (snap) begin
        m_d = digits;
        m_dp = dp_in;
        m_en = den;
        m_pend = 1'b0;
      end
      if (m_presc == DIV - 1) begin
        m_presc = 0;
        m_idx = (m_idx + 1) % N;
      end else m_presc++;
    end
  endtask

  task automatic tick();
    out_t e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL sb_empty: observed queue size 0, expected 1");
    end else begin
      e = q.pop_front();
      check("scoreboard", dut_out(), e);
    end
    n_chk++;
    assert ($countones(~an) <= 1) else begin
      n_fail++;
      $error("FAIL one_anode: observed an=%b, expected at most one low", an);
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    #1 rst = 1'b0;
    #1 expect_now("reset_state", 4'hF, 7'h7F, 1'b1, 1'b0);
    ticks(2);
    expect_now("reset_hold", 4'hF, 7'h7F, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    expect_now("first_snapshot", 4'hF, 7'h7F, 1'b1, 1'b1);
    tick();
    expect_now("slot0_3210", 4'hE, 7'h40, 1'b1, 1'b0);
    ticks(3);
    expect_now("guard_slot1", 4'hF, 7'h7F, 1'b1, 1'b0);
    tick();
    expect_now("slot1_3210", 4'hD, 7'h79, 1'b1, 1'b0);
    digits = 16'hFEDC;
    ticks(4);
    expect_now("slot2_still_old", 4'hB, 7'h24, 1'b1, 1'b0);
    ticks(4);
    expect_now("slot3_still_old", 4'h7, 7'h30, 1'b1, 1'b0);
    ticks(2);
    expect_now("frame_wrap", 4'h7, 7'h30, 1'b1, 1'b1);
    ticks(2);
    expect_now("new_slot0_C", 4'hE, 7'h46, 1'b1, 1'b0);
    ticks(4);
    expect_now("new_slot1_d", 4'hD, 7'h21, 1'b1, 1'b0);
    ticks(4);
    expect_now("new_slot2_E", 4'hB, 7'h06, 1'b1, 1'b0);
    ticks(4);
    expect_now("new_slot3_F", 4'h7, 7'h0E, 1'b1, 1'b0);
    den = 4'b0101;
    dp_in = 4'b0001;
    ticks(2);
    expect_now("frame_2", 4'h7, 7'h0E, 1'b1, 1'b1);
    ticks(2);
    expect_now("slot0_dp_lit", 4'hE, 7'h46, 1'b0, 1'b0);
    ticks(4);
    expect_now("slot1_blanked", 4'hF, 7'h7F, 1'b1, 1'b0);
    ticks(4);
    expect_now("slot2_shown", 4'hB, 7'h06, 1'b1, 1'b0);
    en = 1'b0;
    tick();
    expect_now("disable_blank", 4'hF, 7'h7F, 1'b1, 1'b0);
    ticks(9);
    expect_now("disable_hold", 4'hF, 7'h7F, 1'b1, 1'b0);
    en = 1'b1;
    tick();
    expect_now("resume_slot2", 4'hB, 7'h06, 1'b1, 1'b0);
    ticks(6);
    digits = 16'h9A5B;
    rst = 1'b0;
    model_reset();
    q.delete();
    #1 expect_now("async_reset_blank", 4'hF, 7'h7F, 1'b1, 1'b0);
    ticks(2);
    rst = 1'b1;
    tick();
    expect_now("resnapshot", 4'hF, 7'h7F, 1'b1, 1'b1);
    tick();
    expect_now("post_reset_slot0", 4'hE, 7'h03, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      digits = 16'($urandom);
      dp_in = 4'($urandom);
      den = 4'($urandom);
      ticks(7 + k);
    end
    ticks(32);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
